truth_table_checker: RTL and testbench

Clocked exhaustive-sweep tester for small combinational blocks.
- Steps a counter through every input combination of an N_IN-input DUT and drives each vector for a settle window.
- Samples the DUT's single output at the end of each window and builds the observed truth table.
- Compares the observed table against a parameterised expected table and reports pass/fail, mismatch count and first failing vector.
- Sits beside the DUT on-chip or in a bench wrapper, and is the capture/compare end of the stimulus-drive flow.

---
 rtl/truth_table_checker.sv | 126 ++++++++++++
 tb/tb_truth_table_checker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every input vector of a small combinational block,
// captures its single output per vector and compares against an expected table.
module truth_table_checker #(
    parameter int                     N_IN     = 3,
    parameter int                     SETTLE   = 1,
    parameter logic [(1<<N_IN)-1:0]   EXPECTED = 8'b1110_1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [N_IN-1:0]        vec_out,
    output logic                   vec_valid,
    input  logic                   f_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   captured,
    output logic [N_IN:0]          mismatch_count,
    output logic [N_IN-1:0]        first_fail,
    output logic                   first_fail_valid
);
    localparam int NV = 1 << N_IN;
    localparam int MW = N_IN + 1;
    localparam int SW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
    localparam logic [N_IN-1:0] LAST  = N_IN'(NV - 1);
    localparam logic [SW-1:0]   SLOAD = SW'(SETTLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [NV-1:0]     cap_q, cap_d;
    logic [MW-1:0]     mm_q, mm_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              ffv_q, ffv_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              miss;

    assign miss = f_in != EXPECTED[vec_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            cap_q    <= '0;
            mm_q     <= '0;
            ff_q     <= '0;
            ffv_q    <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            cap_q    <= cap_d;
            mm_q     <= mm_d;
            ff_q     <= ff_d;
            ffv_q    <= ffv_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    // f_in is only looked at when the settle counter has run down to zero
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        cap_d    = cap_q;
        mm_d     = mm_q;
        ff_d     = ff_q;
        ffv_d    = ffv_q;
        done_d   = done_q;
        pass_d   = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    vec_d    = '0;
                    settle_d = SLOAD;
                    cap_d    = '0;
                    mm_d     = '0;
                    ff_d     = '0;
                    ffv_d    = 1'b0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                end
            end
            RUN: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - SW'(1);
                end else begin
                    cap_d[vec_q] = f_in;
                    mm_d = mm_q + MW'(miss);
                    if (miss && !ffv_q) begin
                        ff_d  = vec_q;
                        ffv_d = 1'b1;
                    end
                    if (vec_q == LAST) begin
                        state_d = DONE;
                        vec_d   = '0;
                        done_d  = 1'b1;
                        pass_d  = mm_d == '0;
                    end else begin
                        vec_d    = vec_q + N_IN'(1);
                        settle_d = SLOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign vec_out          = vec_q;
    assign vec_valid        = state_q == RUN;
    assign busy             = state_q == RUN;
    assign done             = done_q;
    assign pass             = pass_q;
    assign captured         = cap_q;
    assign mismatch_count   = mm_q;
    assign first_fail       = ff_q;
    assign first_fail_valid = ffv_q;
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: directed sweeps with a scoreboard of expected results
// popped by per-instance monitors when done rises.
module tb_truth_table_checker;
    typedef struct packed {
        logic [7:0] cap;
        logic [3:0] mm;
        logic [2:0] ff;
        logic       ffv;
        logic       pass;
        int         lat;
    } exp_t;

    logic clk = 0, rst = 1, start1 = 0, start2 = 0;
    int   mode = 0, cyc = 0, t0_1 = 0, t0_2 = 0;
    int   checks = 0, errors = 0;
    exp_t q1[$], q2[$];
    logic d1p = 0, d2p = 0;
    logic [1:0] age = 0;

    logic [2:0] vec_out1, vec_out2, ff1, ff2;
    logic       vec_valid1, vec_valid2, busy1, busy2, done1, done2;
    logic       pass1, pass2, ffv1, ffv2, f1, f2;
    logic [7:0] cap1, cap2;
    logic [3:0] mm1, mm2;

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;
    always @(posedge clk) age <= start2 ? 2'd0 : age + 2'd1;

    function automatic logic maj(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    assign f1 = mode == 0 ? maj(vec_out1) : mode == 1 ? 1'b0 : mode == 2 ? ~maj(vec_out1) : vec_out1[2];
    assign f2 = age == 2'd3 ? maj(vec_out2) : ~maj(vec_out2);

    truth_table_checker #(.N_IN(3), .SETTLE(1), .EXPECTED(8'hE8)) u1 (
        .clk(clk), .rst(rst), .start(start1), .vec_out(vec_out1), .vec_valid(vec_valid1),
        .f_in(f1), .busy(busy1), .done(done1), .pass(pass1), .captured(cap1),
        .mismatch_count(mm1), .first_fail(ff1), .first_fail_valid(ffv1));

    truth_table_checker #(.N_IN(3), .SETTLE(3), .EXPECTED(8'hE8)) u2 (
        .clk(clk), .rst(rst), .start(start2), .vec_out(vec_out2), .vec_valid(vec_valid2),
        .f_in(f2), .busy(busy2), .done(done2), .pass(pass2), .captured(cap2),
        .mismatch_count(mm2), .first_fail(ff2), .first_fail_valid(ffv2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] c, input logic [3:0] m, input logic [2:0] f,
                                input logic fv, input logic p, input int l);
        exp_t e;
        e.cap = c; e.mm = m; e.ff = f; e.ffv = fv; e.pass = p; e.lat = l;
        return e;
    endfunction

    always begin : mon1
        exp_t e;
        @(posedge clk); #1;
        if (done1 && !d1p) begin
            if (q1.size() == 0) chk("u1_unexpected_done", done1, 0);
            else begin
                e = q1.pop_front();
                chk("u1_captured", cap1, e.cap);
                chk("u1_mismatch", mm1, e.mm);
                chk("u1_first_fail", ff1, e.ff);
                chk("u1_ff_valid", ffv1, e.ffv);
                chk("u1_pass", pass1, e.pass);
                chk("u1_latency", cyc - t0_1, e.lat);
                chk("u1_idle_flags", {busy1, vec_valid1, vec_out1}, 0);
            end
        end
        d1p = done1;
    end

    always begin : mon2
        exp_t e;
        @(posedge clk); #1;
        if (done2 && !d2p) begin
            if (q2.size() == 0) chk("u2_unexpected_done", done2, 0);
            else begin
                e = q2.pop_front();
                chk("u2_captured", cap2, e.cap);
                chk("u2_mismatch", mm2, e.mm);
                chk("u2_ff_valid", ffv2, e.ffv);
                chk("u2_pass", pass2, e.pass);
                chk("u2_latency", cyc - t0_2, e.lat);
            end
        end
        d2p = done2;
    end

    task automatic sweep1(input int m, input bit push, input exp_t e);
        @(negedge clk);
        mode = m;
        start1 = 1;
        if (push) q1.push_back(e);
        @(posedge clk);
        t0_1 = cyc;
        @(negedge clk);
        start1 = 0;
    endtask

    task automatic wait_done1();
        int n = 0;
        while (done1 !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        chk("u1_done_timeout", done1, 1);
    endtask

    task automatic wait_vec1(input logic [2:0] v);
        int n = 0;
        while (vec_out1 !== v && n < 100) begin @(posedge clk); #1; n++; end
        chk("u1_wait_vec", vec_out1, v);
    endtask

    initial begin
        exp_t ok = mk(8'hE8, 4'd0, 3'd0, 1'b0, 1'b1, 16);
        repeat (2) @(posedge clk);
        #1;
        chk("u1_reset", {vec_out1, vec_valid1, busy1, done1, pass1, cap1, mm1, ff1, ffv1}, 0);
        chk("u2_reset", {vec_out2, vec_valid2, busy2, done2, pass2, cap2, mm2, ff2, ffv2}, 0);
        @(negedge clk);
        rst = 0;

        sweep1(0, 1, ok);
        chk("u1_run_flags", {busy1, vec_valid1, vec_out1}, 5'b11_000);
        wait_done1();
        sweep1(1, 1, mk(8'h00, 4'd4, 3'd3, 1'b1, 1'b0, 16));
        wait_done1();
        sweep1(2, 1, mk(8'h17, 4'd8, 3'd0, 1'b1, 1'b0, 16));
        wait_done1();
        sweep1(3, 1, mk(8'hF0, 4'd2, 3'd3, 1'b1, 1'b0, 16));
        wait_done1();

        // restart from DONE clears the previous failing results, then a stray start mid-sweep
        sweep1(0, 1, ok);
        chk("u1_restart_clear", {done1, pass1, cap1, mm1, ffv1}, 0);
        wait_vec1(3'd4);
        @(negedge clk); start1 = 1;
        @(negedge clk); start1 = 0;
        wait_done1();

        // reset mid-sweep aborts with nothing pushed, then a clean sweep
        sweep1(1, 0, ok);
        wait_vec1(3'd5);
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        chk("u1_midreset", {vec_out1, vec_valid1, busy1, done1, pass1, cap1, mm1, ff1, ffv1}, 0);
        @(negedge clk); rst = 0;
        repeat (3) @(negedge clk);
        chk("u1_stays_idle", {busy1, done1}, 0);
        sweep1(1, 1, mk(8'h00, 4'd4, 3'd3, 1'b1, 1'b0, 16));
        wait_done1();

        // SETTLE=3 instance with glitching f_in
        @(negedge clk);
        start2 = 1;
        q2.push_back(mk(8'hE8, 4'd0, 3'd0, 1'b0, 1'b1, 32));
        @(posedge clk);
        t0_2 = cyc;
        @(negedge clk);
        start2 = 0;
        begin
            int n = 0;
            while (done2 !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
            chk("u2_done_timeout", done2, 1);
        end

        repeat (4) @(negedge clk);
        chk("u1_queue_drained", q1.size(), 0);
        chk("u2_queue_drained", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
